// File: rtl/glb_multibank_buff_pkg.sv
// rtl/glb_multibank_buff_pkg.sv - shared types, width helpers and config clamps for the global buffer
package glb_pkg;

  typedef enum logic {GLB_STREAM = 1'b0, GLB_REUSE = 1'b1} glb_mode_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int clamp_win(input int cfg, input int depth);
    if (cfg < 1) return 1;
    if (cfg > depth) return depth;
    return cfg;
  endfunction

  function automatic int clamp_stride(input int cfg, input int win);
    if (cfg < 1) return 1;
    if (cfg > win) return win;
    return cfg;
  endfunction

  function automatic int clamp_passes(input int cfg);
    return (cfg < 1) ? 1 : cfg;
  endfunction

endpackage

// File: rtl/glb_multibank_buff_if.sv
// rtl/glb_multibank_buff_if.sv - shared write port and per-bank read streams of the global buffer
interface glb_multibank_buff_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANK   = 4,
  parameter int BANK_W     = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
);
  logic                           wr_valid;
  logic                           wr_ready;
  logic [BANK_W-1:0]              wr_bank;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic [NUM_BANK-1:0]            rd_valid;
  logic [NUM_BANK-1:0]            rd_ready;
  logic [NUM_BANK*DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_bank, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_bank, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/glb_multibank_buff_bank.sv
// rtl/glb_multibank_buff_bank.sv - one circular bank with window-replay read pointer
module glb_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int CFG_W      = 8,
  parameter int PW         = 6,
  parameter int CW         = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [CW-1:0]         win,
  input  logic [CW-1:0]         stride,
  input  logic [CFG_W-1:0]      passes,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count, rd_off;
  logic [CFG_W-1:0]      pass;
  logic                  rd_fire, last_word, last_pass, retire;

  assign rd_valid  = (count >= win);
  // Gated so a freshly reset bank presents zero instead of stale storage.
  assign rd_data   = rd_valid ? mem[head + rd_off[PW-1:0]] : '0;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign rd_fire   = rd_valid & rd_ready;
  assign last_word = (rd_off == win - 1'b1);
  assign last_pass = (pass == passes - 1'b1);
  assign retire    = rd_fire & last_word & last_pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      rd_off <= '0;
      pass   <= '0;
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      rd_off <= '0;
      pass   <= '0;
    end else begin
      if (wr_en) tail <= tail + 1'b1;
      if (rd_fire) begin
        if (!last_word) begin
          rd_off <= rd_off + 1'b1;
        end else begin
          rd_off <= '0;
          pass   <= last_pass ? '0 : pass + 1'b1;
        end
      end
      // Stride may equal DEPTH; truncation to PW bits wraps head correctly.
      if (retire) head <= head + stride[PW-1:0];
      count <= count + CW'(wr_en) - (retire ? stride : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= wr_data;
  end
endmodule

// File: rtl/glb_multibank_buff.sv
// rtl/glb_multibank_buff.sv - multibank global buffer: write demux, effective config, bank array
module glb_multibank_buff
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANK   = 4,
  parameter int DEPTH      = 64,
  parameter int CFG_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 cfg_mode,
  input  logic [CFG_W-1:0]     cfg_win,
  input  logic [CFG_W-1:0]     cfg_stride,
  input  logic [CFG_W-1:0]     cfg_passes,
  glb_multibank_buff_if.slave  bus,
  output logic [NUM_BANK-1:0]  bank_empty,
  output logic [NUM_BANK-1:0]  bank_full
);
  localparam int PW     = ptr_width(DEPTH);
  localparam int CW     = cnt_width(DEPTH);
  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

  glb_mode_e                      mode;
  logic [CW-1:0]                  win, stride;
  logic [CFG_W-1:0]               passes;
  logic [NUM_BANK-1:0]            wr_en, rd_valid;
  logic [NUM_BANK*DATA_WIDTH-1:0] rd_data;

  always_comb begin
    mode   = glb_mode_e'(cfg_mode);
    win    = CW'(1);
    stride = CW'(1);
    passes = CFG_W'(1);
    if (mode == GLB_REUSE) begin
      win    = CW'(clamp_win(int'(cfg_win), DEPTH));
      stride = CW'(clamp_stride(int'(cfg_stride), int'(win)));
      passes = CFG_W'(clamp_passes(int'(cfg_passes)));
    end
  end

  assign bus.wr_ready = ~bank_full[bus.wr_bank];
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    assign wr_en[b] = bus.wr_valid & bus.wr_ready & ~flush & (bus.wr_bank == BANK_W'(b));

    glb_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .CFG_W     (CFG_W),
      .PW        (PW),
      .CW        (CW)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .wr_en   (wr_en[b]),
      .wr_data (bus.wr_data),
      .win     (win),
      .stride  (stride),
      .passes  (passes),
      .rd_ready(bus.rd_ready[b]),
      .rd_valid(rd_valid[b]),
      .rd_data (rd_data[b*DATA_WIDTH +: DATA_WIDTH]),
      .empty   (bank_empty[b]),
      .full    (bank_full[b])
    );
  end
endmodule
